multi_light_controller: RTL and testbench

Parametrised N-channel light controller: each channel has a push-button input that is synchronised, debounced and edge-detected, and each debounced press toggles that channel's light. Each channel has an optional inactivity auto-off timer and a global all-off command. An optional PWM dimmer is compiled in by macro. It sits between raw board buttons/sensors and the LED drive pins, and replaces single-channel free-running toggle logic.

---
 rtl/multi_light_controller.sv | 196 +++++++++++++++++++
 tb/tb_multi_light_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_light_controller.sv
// multi_light_controller
//
// N-channel push-button light controller. Each raw button is passed through
// a 2-flop synchroniser and a debouncer. A rising debounced level is a
// "press" that toggles the channel's light. A lit channel switches itself off
// after TIMEOUT cycles with no activity. A global all_off forces every
// channel off.
//
// Optional build macro: LIGHT_PWM_EN
//   defined   : a free-running PWM_W-bit counter dims every lit channel to
//               the global brightness duty. light is registered one cycle
//               behind on_state.
//   undefined : light = on_state, and brightness is ignored.
//
// Parameters
//   N_CH            number of independent channels (>=1)
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a level
//   TIMEOUT         idle cycles before auto-off; 0 removes the timer
//   PWM_W           brightness / PWM counter width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   btn        raw buttons, asynchronous, 1 = pressed
//   activity   synchronous keep-alive per channel, reloads the timer
//   all_off    synchronous, forces all channels off on the next edge
//   brightness global PWM duty (used with LIGHT_PWM_EN only)
//   light      light drive
//   on_state   registered on/off state per channel
//   expired    one-cycle pulse when a channel times out
module multi_light_controller #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT         = 1000,
  parameter int PWM_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn,
  input  logic [N_CH-1:0]   activity,
  input  logic              all_off,
  input  logic [PWM_W-1:0]  brightness,
  output logic [N_CH-1:0]   light,
  output logic [N_CH-1:0]   on_state,
  output logic [N_CH-1:0]   expired
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {ST_OFF, ST_ON} state_t;

  // Two-flop synchroniser for all channels at once.
  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DB_W-1:0] cnt_reg;
    logic [DB_W-1:0] cnt_next;
    logic            db_reg;
    logic            db_next;
    logic            db_d_reg;
    logic            press;
    logic            expire_hit;
    state_t          state_reg;
    state_t          state_next;
    logic            exp_reg;
    logic            exp_next;

    // Debounce: count consecutive samples that disagree with the accepted
    // level. Any agreeing sample restarts the count, so short glitches are
    // discarded.
    always_comb begin
      cnt_next = cnt_reg;
      db_next  = db_reg;
      if (sync2_reg[gi] == db_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_next  = sync2_reg[gi];
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + DB_W'(1);
      end
    end

    assign press = db_reg & ~db_d_reg;

    // Channel FSM. all_off beats press, and press beats timeout. expired only
    // pulses when the timeout alone caused the switch-off.
    always_comb begin
      state_next = state_reg;
      exp_next   = 1'b0;
      case (state_reg)
        ST_OFF: begin
          if (!all_off && press) begin
            state_next = ST_ON;
          end
        end
        ST_ON: begin
          if (all_off || press) begin
            state_next = ST_OFF;
          end else if (expire_hit) begin
            state_next = ST_OFF;
            exp_next   = 1'b1;
          end
        end
        default: state_next = ST_OFF;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg   <= '0;
        db_reg    <= 1'b0;
        db_d_reg  <= 1'b0;
        state_reg <= ST_OFF;
        exp_reg   <= 1'b0;
      end else begin
        cnt_reg   <= cnt_next;
        db_reg    <= db_next;
        db_d_reg  <= db_reg;
        state_reg <= state_next;
        exp_reg   <= exp_next;
      end
    end

    if (TIMEOUT > 0) begin : g_timer
      logic [TM_W-1:0] timer_reg;
      logic [TM_W-1:0] timer_next;

      // Activity on the last cycle reloads the timer, so the channel stays on.
      assign expire_hit = (timer_reg == TM_W'(1)) && !activity[gi];

      // Load on entry to ON or on activity. Count down while ON. Park at 0
      // while OFF.
      always_comb begin
        timer_next = '0;
        if (state_next == ST_ON) begin
          if (state_reg == ST_OFF || activity[gi]) begin
            timer_next = TM_W'(TIMEOUT);
          end else begin
            timer_next = timer_reg - TM_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          timer_reg <= '0;
        end else begin
          timer_reg <= timer_next;
        end
      end
    end else begin : g_no_timer
      logic unused_activity;
      assign unused_activity = activity[gi];
      assign expire_hit      = 1'b0;
    end

    assign on_state[gi] = (state_reg == ST_ON);
    assign expired[gi]  = exp_reg;
  end

`ifdef LIGHT_PWM_EN
  logic [PWM_W-1:0] pc_reg;
  logic [N_CH-1:0]  light_reg;

  // brightness is compared live, so a change applies on the next compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= '0;
      light_reg <= '0;
    end else begin
      pc_reg    <= pc_reg + PWM_W'(1);
      light_reg <= on_state & {N_CH{(pc_reg < brightness)}};
    end
  end

  assign light = light_reg;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign light             = on_state;
`endif

endmodule

// File: tb/tb_multi_light_controller.sv
// Testbench for multi_light_controller. A reference model derives the
// expected outputs from edge counts and a raw-sample history. A single
// negedge process compares the model with the DUT on every cycle. Directed
// literal checks cover latency, glitch rejection, timeout, all_off priority
// and reset.
module tb_multi_light_controller;
  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int TO   = 10;
  localparam int PW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] activity = '0;
  logic            all_off = 1'b0;
  logic [PW-1:0]   brightness = '0;
  logic [N_CH-1:0] light;
  logic [N_CH-1:0] on_state;
  logic [N_CH-1:0] expired;

  int total   = 0;
  int passed  = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  multi_light_controller #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .TIMEOUT(TO), .PWM_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .activity(activity),
    .all_off(all_off), .brightness(brightness),
    .light(light), .on_state(on_state), .expired(expired)
  );

  // ---------------- reference model ----------------
  // raw_hist bit0 is the btn value sampled at this edge. The synchronised
  // sample that the debouncer sees at this edge is bit 2. The accepted level
  // flips once the last DB synchronised samples all disagree with it. The
  // auto-off deadline is an absolute edge number.
  logic [63:0]     raw_hist [N_CH];
  bit              db_m     [N_CH];
  bit              rose_m   [N_CH];
  int              deadline [N_CH];
  logic [N_CH-1:0] on_m, exp_m, light_m, light_nx;
  int              n, pc_m;
  bit              flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; pc_m = 0;
      on_m = '0; exp_m = '0; light_m = '0; light_nx = '0;
      for (int c = 0; c < N_CH; c++) begin
        raw_hist[c] = '0; db_m[c] = 0; rose_m[c] = 0; deadline[c] = 0;
      end
    end else begin
      n++;
      light_nx = on_m & {N_CH{(pc_m < int'(brightness))}};
      pc_m = (pc_m + 1) % (1 << PW);
      for (int c = 0; c < N_CH; c++) begin
        exp_m[c] = 1'b0;
        if (on_m[c]) begin
          if (all_off || rose_m[c]) on_m[c] = 1'b0;
          else if (TO > 0 && !activity[c] && n == deadline[c]) begin
            on_m[c] = 1'b0; exp_m[c] = 1'b1;
          end else if (activity[c]) deadline[c] = n + TO;
        end else if (!all_off && rose_m[c]) begin
          on_m[c] = 1'b1; deadline[c] = n + TO;
        end
        raw_hist[c] = {raw_hist[c][62:0], btn[c]};
        rose_m[c] = 0;
        flip = 1;
        for (int k = 2; k <= DB + 1; k++)
          if (raw_hist[c][k] == db_m[c]) flip = 0;
        if (flip) begin
          db_m[c] = ~db_m[c];
          rose_m[c] = db_m[c];
        end
      end
`ifdef LIGHT_PWM_EN
      light_m = light_nx;
`else
      light_m = on_m;
`endif
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("on_state", 32'(on_state), 32'(on_m));
      check("light",    32'(light),    32'(light_m));
      check("expired",  32'(expired),  32'(exp_m));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  int hold [N_CH];
  int cnt;

  initial begin
    rst = 1'b1;
    tick(3);
    #1 rst = 1'b0;
    checking = 1'b1;
    check("reset_on", 32'(on_state), 0);
    check("reset_light", 32'(light), 0);
    check("reset_exp", 32'(expired), 0);

    // Press latency on channel 0: on_state rises at edge k+6.
    @(negedge clk);
    btn[0] = 1'b1;
    tick(6);
    check("lat_before", 32'(on_state[0]), 0);
    tick(1);
    check("lat_on", 32'(on_state[0]), 1);
    check("lat_model", 32'(on_m[0]), 1);
    check("lat_others", 32'(on_state[3:1]), 0);
    tick(13);
    btn[0] = 1'b0;
    tick(10);

    // Glitches of 1..3 cycles on channel 1 are rejected.
    for (int len = 1; len <= 3; len++) begin
      btn[1] = 1'b1; tick(len); btn[1] = 1'b0; tick(8);
      check("glitch", 32'(on_state[1]), 0);
    end
    btn[1] = 1'b1; tick(4); btn[1] = 1'b0; tick(3);
    check("pulse4_on", 32'(on_state[1]), 1);
    tick(5);
    check("release_no_toggle", 32'(on_state[1]), 1);
    tick(12);

    // Timeout on channel 2, without and then with activity.
    btn[2] = 1'b1; tick(6); btn[2] = 1'b0; tick(1);
    check("to_on", 32'(on_state[2]), 1);
    tick(9);
    check("to_still_on", 32'(on_state[2]), 1);
    tick(1);
    check("to_off", 32'(on_state[2]), 0);
    check("to_exp", 32'(expired), 32'h4);
    check("to_exp_model", 32'(exp_m), 32'h4);
    tick(1);
    check("to_exp_single", 32'(expired[2]), 0);
    tick(10);
    btn[2] = 1'b1; tick(6); btn[2] = 1'b0; tick(1);
    check("act_on", 32'(on_state[2]), 1);
    tick(4);
    activity[2] = 1'b1; tick(1); activity[2] = 1'b0;
    tick(9);
    check("act_still_on", 32'(on_state[2]), 1);
    tick(1);
    check("act_off", 32'(on_state[2]), 0);
    check("act_exp", 32'(expired[2]), 1);
    tick(10);

    // all_off coinciding with a debounced press on channel 3.
    activity = 4'b1001;
    btn[0] = 1'b1; btn[3] = 1'b1; tick(7);
    check("ao_both_on", 32'({on_state[3], on_state[0]}), 32'h3);
    btn = '0; tick(12);
    btn[3] = 1'b1; tick(6);
    all_off = 1'b1; tick(1); all_off = 1'b0;
    check("ao_off", 32'(on_state), 0);
    check("ao_no_exp", 32'(expired), 0);
    tick(1);
    check("ao_no_exp2", 32'(expired), 0);
    btn = '0; activity = '0; tick(10);

    // Randomised phase.
    for (int c = 0; c < N_CH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          btn[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 12);
        end else hold[c]--;
        activity[c] = ($urandom_range(0, 9) == 0);
      end
      all_off = ($urandom_range(0, 63) == 0);
      if (cyc % 50 == 0) brightness = PW'($urandom);
      tick(1);
    end
    all_off = 1'b0; btn = '0; activity = 4'b1111;
    tick(20);
    all_off = 1'b1; tick(1); all_off = 1'b0;
    check("rand_cleared", 32'(on_state), 0);

    // Reset mid-operation, with the channel 0 button held through release.
    btn[0] = 1'b1; tick(7);
    check("pre_rst_on", 32'(on_state[0]), 1);
    btn[1] = 1'b1; tick(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_on", 32'(on_state), 0);
    check("rst_light", 32'(light), 0);
    check("rst_exp", 32'(expired), 0);
    btn[1] = 1'b0;
    tick(2);
    #1 rst = 1'b0;
    tick(6);
    check("held_before", 32'(on_state[0]), 0);
    tick(1);
    check("held_on", 32'(on_state[0]), 1);
    btn[0] = 1'b0;
    tick(10);

`ifdef LIGHT_PWM_EN
    brightness = 4;
    tick(20);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(1); cnt += int'(light[0]); end
    check("pwm_duty4", 32'(cnt), 4);
    brightness = 0;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(1); cnt += int'(light[0]); end
    check("pwm_duty0", 32'(cnt), 0);
`endif

    activity = '0;
    tick(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
